sw_core_param: RTL and testbench

Parametrised stopwatch/timer core and successor to the fixed control+timer pair. It integrates the tick divider, a run/pause/done control FSM, an up/down H:M:S counter with configurable hour wrap, and a LAP_DEPTH-entry lap-capture FIFO. Binary time outputs feed the existing digit extractor and seven-segment decoders unchanged.

---
 rtl/sw_core_param.sv | 228 ++++++++++++++++++++++
 tb/tb_sw_core_param.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sw_core_param.sv
// rtl/sw_core_param.sv - parametrised stopwatch/timer core with lap FIFO
//
// Purpose: one-second tick divider, IDLE/RUN/PAUSE/DONE control FSM,
// up/down H:M:S counter with configurable hour wrap and a first-word-
// fall-through lap-capture FIFO.
//
// Ports:
//   clk, clr_n            clock, synchronous active-low clear
//   start, pause          one-cycle control pulses (pause wins when both)
//   mode                  0=up, 1=down; latched on start from IDLE
//   load, pre_*           preset load (IDLE/DONE only), clamped to range
//   lap, lap_rd           capture current time / pop FIFO head
//   sec, min, hr          current time
//   run, done, wrap       RUN state, countdown-done pulse, up-wrap pulse
//   lap_q, lap_valid,
//   lap_full, lap_ovf     FIFO head {hr,min,sec} and status flags
module sw_core_param #(
  parameter int TICK_DIV  = 50000000,
  parameter int HR_W      = 5,
  parameter int HR_MAX    = 23,
  parameter int LAP_DEPTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             pause,
  input  logic             mode,
  input  logic             load,
  input  logic [5:0]       pre_sec,
  input  logic [5:0]       pre_min,
  input  logic [HR_W-1:0]  pre_hr,
  input  logic             lap,
  input  logic             lap_rd,
  output logic [5:0]       sec,
  output logic [5:0]       min,
  output logic [HR_W-1:0]  hr,
  output logic             run,
  output logic             done,
  output logic             wrap,
  output logic [11+HR_W:0] lap_q,
  output logic             lap_valid,
  output logic             lap_full,
  output logic             lap_ovf
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW    = $clog2(LAP_DEPTH);
  localparam int LW    = 12 + HR_W;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [HR_W-1:0]  HR_TOP   = HR_W'(HR_MAX);
  localparam logic [AW:0]      CNT_FULL = (AW+1)'(LAP_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t            state_q;
  logic              mode_q;
  logic [DIV_W-1:0]  div_q;
  logic [5:0]        sec_q, min_q;
  logic [HR_W-1:0]   hr_q;
  logic              done_q, wrap_q;

  logic              tick, time_zero, start_only;
  logic [5:0]        ld_sec, ld_min, up_sec, up_min, dn_sec, dn_min;
  logic [HR_W-1:0]   ld_hr, up_hr, dn_hr;
  logic              up_wrap, dn_zero;

  assign tick       = (state_q == S_RUN) && (div_q == DIV_LAST);
  assign time_zero  = (sec_q == 6'd0) && (min_q == 6'd0) && (hr_q == '0);
  assign start_only = start && !pause;

  always_comb begin
    ld_sec = (pre_sec > 6'd59) ? 6'd59 : pre_sec;
    ld_min = (pre_min > 6'd59) ? 6'd59 : pre_min;
    ld_hr  = (pre_hr > HR_TOP) ? HR_TOP : pre_hr;

    up_sec  = sec_q + 6'd1;
    up_min  = min_q;
    up_hr   = hr_q;
    up_wrap = 1'b0;
    if (sec_q >= 6'd59) begin
      up_sec = 6'd0;
      up_min = min_q + 6'd1;
      if (min_q >= 6'd59) begin
        up_min = 6'd0;
        if (hr_q >= HR_TOP) begin
          up_hr   = '0;
          up_wrap = 1'b1;
        end else begin
          up_hr = hr_q + HR_W'(1);
        end
      end
    end

    dn_sec = sec_q - 6'd1;
    dn_min = min_q;
    dn_hr  = hr_q;
    if (sec_q == 6'd0) begin
      dn_sec = 6'd59;
      if (min_q == 6'd0) begin
        dn_min = 6'd59;
        dn_hr  = hr_q - HR_W'(1);
      end else begin
        dn_min = min_q - 6'd1;
      end
    end
    // The decrement lands on 00:00:00 exactly when starting from 00:00:01.
    dn_zero = (hr_q == '0) && (min_q == 6'd0) && (sec_q == 6'd1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      div_q   <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hr_q    <= '0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_only) begin
            state_q <= S_RUN;
            mode_q  <= mode;
          end
          if (load) begin
            sec_q <= ld_sec;
            min_q <= ld_min;
            hr_q  <= ld_hr;
            div_q <= '0;
          end
        end
        S_RUN: begin
          div_q <= tick ? '0 : div_q + DIV_W'(1);
          if (pause) state_q <= S_PAUSE;
          if (tick) begin
            if (!mode_q) begin
              sec_q  <= up_sec;
              min_q  <= up_min;
              hr_q   <= up_hr;
              wrap_q <= up_wrap;
            end else if (time_zero) begin
              // Countdown started from zero: finish without decrementing.
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              sec_q <= dn_sec;
              min_q <= dn_min;
              hr_q  <= dn_hr;
              if (dn_zero) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            end
          end
        end
        S_PAUSE: begin
          if (start_only) state_q <= S_RUN;
        end
        S_DONE: begin
          if (load) begin
            state_q <= S_IDLE;
            sec_q   <= ld_sec;
            min_q   <= ld_min;
            hr_q    <= ld_hr;
            div_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sec  = sec_q;
  assign min  = min_q;
  assign hr   = hr_q;
  assign run  = (state_q == S_RUN);
  assign done = done_q;
  assign wrap = wrap_q;

  // Lap FIFO: captures the registered time before any same-edge tick update.
  logic [LW-1:0] mem_q [LAP_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          valid_q, full_q, ovf_q;
  logic          push_req, push, pop, full_c;

  assign full_c   = (cnt_q == CNT_FULL);
  assign push_req = lap && ((state_q == S_RUN) || (state_q == S_PAUSE));
  assign pop      = lap_rd && (cnt_q != '0);
  assign push     = push_req && (!full_c || pop);

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
    else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {hr_q, min_q, sec_q};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_req && full_c && !pop) ovf_q <= 1'b1;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      full_q  <= (cnt_d == CNT_FULL);
    end
  end

  assign lap_q     = mem_q[rd_ptr_q];
  assign lap_valid = valid_q;
  assign lap_full  = full_q;
  assign lap_ovf   = ovf_q;

endmodule

// File: tb/tb_sw_core_param.sv
// tb/tb_sw_core_param.sv - directed self-checking bench for sw_core_param
module tb_sw_core_param;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0, pause = 1'b0, mode = 1'b0, load = 1'b0;
  logic [5:0]  pre_sec = 6'd0, pre_min = 6'd0;
  logic [4:0]  pre_hr = 5'd0;
  logic        lap = 1'b0, lap_rd = 1'b0;
  logic [5:0]  sec, min;
  logic [4:0]  hr;
  logic        run, done, wrap;
  logic [16:0] lap_q;
  logic        lap_valid, lap_full, lap_ovf;

  int checks = 0;
  int failures = 0;

  sw_core_param #(.TICK_DIV(4), .HR_W(5), .HR_MAX(1), .LAP_DEPTH(4)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .pause(pause), .mode(mode),
    .load(load), .pre_sec(pre_sec), .pre_min(pre_min), .pre_hr(pre_hr),
    .lap(lap), .lap_rd(lap_rd), .sec(sec), .min(min), .hr(hr), .run(run),
    .done(done), .wrap(wrap), .lap_q(lap_q), .lap_valid(lap_valid),
    .lap_full(lap_full), .lap_ovf(lap_ovf)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] tv(input int h, input int m, input int s);
    logic [4:0] hh;
    logic [5:0] mm, ss;
    hh = 5'(h);
    mm = 6'(m);
    ss = 6'(s);
    return {15'd0, hh, mm, ss};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    clr_n = 1'b1;
    cyc(1);
    chk("rst_time", {hr, min, sec}, tv(0, 0, 0));
    chk("rst_run", run, 0);
    chk("rst_done", done, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_valid", lap_valid, 0);
    chk("rst_full", lap_full, 0);
    chk("rst_ovf", lap_ovf, 0);

    // Up count: first tick 4 cycles after the RUN entry edge
    start = 1'b1; cyc(1); start = 1'b0;
    chk("up_run", run, 1);
    cyc(3);
    chk("up_pre_tick", {hr, min, sec}, tv(0, 0, 0));
    cyc(1);
    chk("up_tick1", {hr, min, sec}, tv(0, 0, 1));
    cyc(240);
    chk("up_244", {hr, min, sec}, tv(0, 1, 1));

    // Pause with divider frozen at 2, resume reaches tick after 2 cycles
    cyc(1);
    pause = 1'b1; cyc(1); pause = 1'b0;
    chk("pause_run", run, 0);
    cyc(100);
    chk("pause_frozen", {hr, min, sec}, tv(0, 1, 1));
    start = 1'b1; cyc(1); start = 1'b0;
    chk("resume_run", run, 1);
    cyc(1);
    chk("resume_c1", {hr, min, sec}, tv(0, 1, 1));
    cyc(1);
    chk("resume_c2", {hr, min, sec}, tv(0, 1, 2));

    // start+pause together: RUN->PAUSE, PAUSE stays PAUSE
    start = 1'b1; pause = 1'b1; cyc(1);
    chk("both_run", run, 0);
    cyc(1); start = 1'b0; pause = 1'b0;
    chk("both_pause", run, 0);

    // Five laps one second apart while running; fifth is dropped
    start = 1'b1; cyc(1); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lap = 1'b1; cyc(1); lap = 1'b0;
      cyc(3);
    end
    chk("lap_full", lap_full, 1);
    chk("lap_ovf", lap_ovf, 1);
    chk("lap_time", {hr, min, sec}, tv(0, 1, 7));
    pause = 1'b1; cyc(1); pause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lap_valid_pop", lap_valid, 1);
      chk("lap_head", lap_q, tv(0, 1, 2 + i));
      lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    end
    chk("lap_empty", lap_valid, 0);
    chk("lap_notfull", lap_full, 0);
    chk("lap_ovf_sticky", lap_ovf, 1);
    lap_rd = 1'b1; cyc(1); lap_rd = 1'b0;
    chk("pop_empty", lap_valid, 0);

    // Lap on the tick edge captures the pre-update time
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(1);
    lap = 1'b1; cyc(1); lap = 1'b0;
    chk("lap_tick_time", {hr, min, sec}, tv(0, 1, 8));
    chk("lap_tick_head", lap_q, tv(0, 1, 7));
    chk("lap_tick_valid", lap_valid, 1);

    // Clear mid-run with FIFO non-empty
    clr_n = 1'b0; cyc(1); clr_n = 1'b1;
    chk("clr_time", {hr, min, sec}, tv(0, 0, 0));
    chk("clr_run", run, 0);
    chk("clr_valid", lap_valid, 0);
    chk("clr_ovf", lap_ovf, 0);
    chk("clr_full", lap_full, 0);
    cyc(5);
    chk("clr_idle_time", {hr, min, sec}, tv(0, 0, 0));
    chk("clr_idle_run", run, 0);

    // Preset clamping (HR_MAX=1)
    pre_sec = 6'd63; pre_min = 6'd60; pre_hr = 5'd5;
    load = 1'b1; cyc(1); load = 1'b0;
    chk("clamp", {hr, min, sec}, tv(1, 59, 59));

    // Hour wrap
    pre_sec = 6'd58; pre_min = 6'd59; pre_hr = 5'd1;
    load = 1'b1; cyc(1); load = 1'b0;
    chk("wrap_load", {hr, min, sec}, tv(1, 59, 58));
    mode = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(4);
    chk("wrap_t1", {hr, min, sec}, tv(1, 59, 59));
    cyc(3);
    chk("wrap_pre", wrap, 0);
    cyc(1);
    chk("wrap_time", {hr, min, sec}, tv(0, 0, 0));
    chk("wrap_pulse", wrap, 1);
    chk("wrap_run", run, 1);
    cyc(1);
    chk("wrap_end", wrap, 0);

    // Countdown from 00:01:02
    clr_n = 1'b0; cyc(1); clr_n = 1'b1;
    mode = 1'b1;
    pre_sec = 6'd2; pre_min = 6'd1; pre_hr = 5'd0;
    load = 1'b1; cyc(1); load = 1'b0;
    start = 1'b1; cyc(1); start = 1'b0;
    mode = 1'b0;
    cyc(8);
    chk("dn_t2", {hr, min, sec}, tv(0, 1, 0));
    pre_sec = 6'd5; pre_min = 6'd0; pre_hr = 5'd0;
    load = 1'b1; cyc(1); load = 1'b0;
    chk("dn_load_ign", {hr, min, sec}, tv(0, 1, 0));
    cyc(3);
    chk("dn_t3", {hr, min, sec}, tv(0, 0, 59));
    cyc(235);
    chk("dn_t61", {hr, min, sec}, tv(0, 0, 1));
    chk("dn_t61_done", done, 0);
    chk("dn_t61_run", run, 1);
    cyc(1);
    chk("dn_done", done, 1);
    chk("dn_zero", {hr, min, sec}, tv(0, 0, 0));
    chk("dn_state", run, 0);
    cyc(1);
    chk("dn_done_end", done, 0);
    start = 1'b1; cyc(1); start = 1'b0;
    chk("done_start_ign", run, 0);
    chk("done_no_repulse", done, 0);
    load = 1'b1; cyc(1); load = 1'b0;
    chk("done_load", {hr, min, sec}, tv(0, 0, 5));
    start = 1'b1; cyc(1); start = 1'b0;
    chk("idle_after_load", run, 1);

    // Countdown started at 00:00:00
    clr_n = 1'b0; cyc(1); clr_n = 1'b1;
    mode = 1'b1;
    start = 1'b1; cyc(1); start = 1'b0;
    mode = 1'b0;
    chk("z_run", run, 1);
    cyc(3);
    chk("z_pre", run, 1);
    chk("z_pre_time", {hr, min, sec}, tv(0, 0, 0));
    cyc(1);
    chk("z_done_state", run, 0);
    chk("z_time", {hr, min, sec}, tv(0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
